// File: rtl/mmio_fifo_pkg.sv
// Shared constants, CCI-P transport types and the status-word packer for the
// MMIO FIFO AFU.
package mmio_fifo_pkg;

    localparam int unsigned FIFO_STRIDE   = 4;
    localparam int unsigned STATUS_OFFSET = 2;

    localparam int unsigned ST_EMPTY = 16;
    localparam int unsigned ST_FULL  = 17;
    localparam int unsigned ST_OVF   = 18;
    localparam int unsigned ST_UNF   = 19;
    localparam int unsigned ST_FLUSH = 63;

    localparam logic [15:0] CSR_DFH     = 16'h0000;
    localparam logic [15:0] CSR_ID_L    = 16'h0002;
    localparam logic [15:0] CSR_ID_H    = 16'h0004;

    // Type AFU in [63:60], end-of-list in bit 40, everything else zero.
    localparam logic [63:0]  AFU_DFH        = {4'h1, 19'b0, 1'b1, 40'b0};
    localparam logic [127:0] AFU_ACCEL_UUID = 128'h8a4c_2f3e_91d0_4b7a_a6e5_3c1f_0d92_b847;

    typedef logic [15:0] t_ccip_mmioAddr;
    typedef logic [8:0]  t_ccip_tid;
    typedef logic [27:0] t_ccip_c0_RspHdr;

    typedef struct packed {
        t_ccip_mmioAddr address;
        logic [1:0]     length;
        logic           rsvd;
        t_ccip_tid      tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_RspHdr hdr;
        logic [511:0]    data;
        logic            rspValid;
        logic            mmioRdValid;
        logic            mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_if_ccip_c0_Rx c0;
    } t_if_ccip_Rx;

    typedef struct packed {
        t_ccip_tid tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        logic [73:0] hdr;
        logic        valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        logic [79:0]  hdr;
        logic [511:0] data;
        logic         valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    function automatic logic [63:0] status_word(input logic [15:0] cnt, input logic empty,
                                               input logic full, input logic ovf, input logic unf);
        logic [63:0] sw;
        sw           = '0;
        sw[15:0]     = cnt;
        sw[ST_EMPTY] = empty;
        sw[ST_FULL]  = full;
        sw[ST_OVF]   = ovf;
        sw[ST_UNF]   = unf;
        return sw;
    endfunction

endpackage

// File: rtl/mmio_fifo_afu_if.sv
// CCI-P receive/transmit bundle between the host shell (master) and the AFU (slave).
interface mmio_fifo_afu_if;
    import mmio_fifo_pkg::*;

    t_if_ccip_Rx rx;
    t_if_ccip_Tx tx;

    modport master (output rx, input tx);
    modport slave  (input rx, output tx);

endinterface

// File: rtl/mmio_fifo.sv
// One host-visible FIFO: register-array storage, wrapping pointers, occupancy
// count and sticky overflow/underflow flags.
module mmio_fifo #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic                    clr_ovf,
    input  logic                    clr_unf,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    ovf,
    output logic                    unf
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    // NOTE: storage is deliberately unreset; an entry is only visible after a push wrote it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
                count  <= count + CW'(1);
            end else if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                count  <= count - CW'(1);
            end

            // An error event on the same cycle as a clear leaves the flag set.
            if (push && full)     ovf <= 1'b1;
            else if (clr_ovf)     ovf <= 1'b0;

            if (pop && empty)     unf <= 1'b1;
            else if (clr_unf)     unf <= 1'b0;
        end
    end

endmodule

// File: rtl/mmio_fifo_afu.sv
// CCI-P AFU exposing NUM_FIFOS MMIO FIFOs plus the DFH/AFU-ID CSRs; reads are
// answered on c2 exactly one cycle after the request.
module mmio_fifo_afu
    import mmio_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned NUM_FIFOS  = 2,
    parameter logic [15:0] BASE_ADDR  = 16'h0020
) (
    input  logic          clk,
    input  logic          rst,
    mmio_fifo_afu_if.slave ccip
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    t_ccip_c0_ReqMmioHdr req_hdr;
    logic                rd_valid;
    logic                wr_valid;
    logic                unused_rx;

    assign req_hdr   = t_ccip_c0_ReqMmioHdr'(ccip.rx.c0.hdr);
    assign rd_valid  = ccip.rx.c0.mmioRdValid;
    assign wr_valid  = ccip.rx.c0.mmioWrValid;
    assign unused_rx = ^{ccip.rx.c0.data, ccip.rx.c0.rspValid, req_hdr.length, req_hdr.rsvd};

    logic [NUM_FIFOS-1:0]  data_hit, status_hit;
    logic [NUM_FIFOS-1:0]  push, pop, flush, clr_ovf, clr_unf;
    logic [NUM_FIFOS-1:0]  full, empty, ovf, unf;
    logic [DATA_WIDTH-1:0] dout  [NUM_FIFOS];
    logic [CW-1:0]         count [NUM_FIFOS];

    for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_fifo
        assign data_hit[i]   = (req_hdr.address == BASE_ADDR + 16'(FIFO_STRIDE * i));
        assign status_hit[i] = (req_hdr.address == BASE_ADDR + 16'(FIFO_STRIDE * i + STATUS_OFFSET));

        assign push[i]    = wr_valid && data_hit[i];
        assign pop[i]     = rd_valid && data_hit[i];
        assign flush[i]   = wr_valid && status_hit[i] && ccip.rx.c0.data[ST_FLUSH];
        assign clr_ovf[i] = wr_valid && status_hit[i] && ccip.rx.c0.data[ST_OVF];
        assign clr_unf[i] = wr_valid && status_hit[i] && ccip.rx.c0.data[ST_UNF];

        mmio_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push    (push[i]),
            .pop     (pop[i]),
            .flush   (flush[i]),
            .clr_ovf (clr_ovf[i]),
            .clr_unf (clr_unf[i]),
            .din     (ccip.rx.c0.data[DATA_WIDTH-1:0]),
            .dout    (dout[i]),
            .count   (count[i]),
            .full    (full[i]),
            .empty   (empty[i]),
            .ovf     (ovf[i]),
            .unf     (unf[i])
        );
    end

    logic [63:0] rd_data;

    // NOTE: default assigned first so no path through this block infers a latch.
    always_comb begin
        rd_data = '0;
        case (req_hdr.address)
            CSR_DFH:  rd_data = AFU_DFH;
            CSR_ID_L: rd_data = AFU_ACCEL_UUID[63:0];
            CSR_ID_H: rd_data = AFU_ACCEL_UUID[127:64];
            default:  rd_data = '0;
        endcase
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (data_hit[i] && !empty[i]) rd_data = 64'(dout[i]);
            if (status_hit[i]) rd_data = status_word(16'(count[i]), empty[i], full[i], ovf[i], unf[i]);
        end
    end

    t_if_ccip_c2_Tx c2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c2_q <= '0;
        end else begin
            c2_q.mmioRdValid <= rd_valid;
            if (rd_valid) begin
                c2_q.hdr.tid <= req_hdr.tid;
                c2_q.data    <= rd_data;
            end
        end
    end

    always_comb begin
        ccip.tx    = '0;
        ccip.tx.c2 = c2_q;
    end

endmodule

// File: tb/tb_mmio_fifo_afu.sv
// Directed bench for mmio_fifo_afu: table of MMIO reads/writes with expected
// read data, plus sequences for timing, flush/wrap, reset and narrow data.
module tb_mmio_fifo_afu;
    import mmio_fifo_pkg::*;

    localparam logic [63:0] EXP_DFH  = 64'h1000_0100_0000_0000;
    localparam logic [63:0] EXP_IDL  = 64'ha6e5_3c1f_0d92_b847;
    localparam logic [63:0] EXP_IDH  = 64'h8a4c_2f3e_91d0_4b7a;
    localparam logic [63:0] ST_MT    = 64'h0000_0000_0001_0000;
    localparam logic [63:0] FLUSH_W  = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmio_fifo_afu_if ccip ();
    mmio_fifo_afu_if ccip16 ();
    assign ccip16.rx = ccip.rx;

    mmio_fifo_afu #(.DATA_WIDTH(64), .DEPTH(8), .NUM_FIFOS(2), .BASE_ADDR(16'h0020)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .ccip (ccip)
    );

    mmio_fifo_afu #(.DATA_WIDTH(16), .DEPTH(8), .NUM_FIFOS(2), .BASE_ADDR(16'h0020)) u_dut16 (
        .clk  (clk),
        .rst  (rst),
        .ccip (ccip16)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [8:0] tid, input logic [63:0] data);
        t_ccip_c0_ReqMmioHdr h;
        h = '0;
        h.address = addr;
        h.tid     = tid;
        ccip.rx.c0.hdr         = h;
        ccip.rx.c0.mmioRdValid = rd;
        ccip.rx.c0.mmioWrValid = wr;
        ccip.rx.c0.rspValid    = 1'b0;
        ccip.rx.c0.data        = 512'(data);
    endtask

    // Every operation starts on a falling edge and returns on the next one.
    task automatic mmio_wr(input logic [15:0] addr, input logic [63:0] data);
        drive(1'b0, 1'b1, addr, 9'd0, data);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 9'd0, 64'h0);
    endtask

    task automatic mmio_rd(input string name, input logic [15:0] addr, input logic [8:0] tid,
                           input logic [63:0] exp);
        drive(1'b1, 1'b0, addr, tid, 64'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 9'd0, 64'h0);
        check({name, " vld"}, 64'(ccip.tx.c2.mmioRdValid), 64'd1);
        check({name, " tid"}, 64'(ccip.tx.c2.hdr.tid), 64'(tid));
        check({name, " data"}, ccip.tx.c2.data, exp);
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [63:0] data;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic wr, input logic [15:0] addr, input logic [63:0] data);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data;
        vecs.push_back(v);
    endfunction

    initial begin
        // CSRs and unmapped space
        add(0, 16'h0000, EXP_DFH);
        add(0, 16'h0002, EXP_IDL);
        add(0, 16'h0004, EXP_IDH);
        add(0, 16'h0006, 64'h0);
        add(0, 16'h0008, 64'h0);
        add(0, 16'h0030, 64'h0);
        add(1, 16'h0028, 64'h77);
        add(0, 16'h0022, ST_MT);
        add(0, 16'h0026, ST_MT);
        // basic FIFO 0 order
        add(1, 16'h0020, 64'd1); add(1, 16'h0020, 64'd2); add(1, 16'h0020, 64'd3);
        add(0, 16'h0022, 64'h3);
        add(0, 16'h0020, 64'd1); add(0, 16'h0020, 64'd2); add(0, 16'h0020, 64'd3);
        add(0, 16'h0022, ST_MT);
        // overflow
        for (int k = 10; k <= 18; k++) add(1, 16'h0020, 64'(k));
        add(0, 16'h0022, 64'h0006_0008);
        for (int k = 10; k <= 17; k++) add(0, 16'h0020, 64'(k));
        add(0, 16'h0022, 64'h0005_0000);
        add(1, 16'h0022, 64'h0004_0000);
        add(0, 16'h0022, ST_MT);
        // underflow and FIFO independence
        add(0, 16'h0024, 64'h0);
        add(0, 16'h0026, 64'h0009_0000);
        add(0, 16'h0022, ST_MT);
        add(1, 16'h0024, 64'd7);
        add(1, 16'h0020, 64'd9);
        add(0, 16'h0024, 64'd7);
        add(0, 16'h0020, 64'd9);
        add(0, 16'h0026, 64'h0009_0000);
        add(1, 16'h0026, 64'h0008_0000);
        add(0, 16'h0026, ST_MT);

        drive(1'b0, 1'b0, 16'h0, 9'd0, 64'h0);
        repeat (2) @(negedge clk);
        check("reset c2 vld", 64'(ccip.tx.c2.mmioRdValid), 64'd0);
        check("reset tx nonzero", 64'(ccip.tx != '0), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Response timing: one cycle later, single-cycle pulse.
        drive(1'b1, 1'b0, 16'h0000, 9'd5, 64'h0);
        check("rsp early", 64'(ccip.tx.c2.mmioRdValid), 64'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 9'd0, 64'h0);
        check("rsp vld", 64'(ccip.tx.c2.mmioRdValid), 64'd1);
        check("rsp tid", 64'(ccip.tx.c2.hdr.tid), 64'd5);
        check("rsp dfh", ccip.tx.c2.data, EXP_DFH);
        @(negedge clk);
        check("rsp pulse", 64'(ccip.tx.c2.mmioRdValid), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) mmio_wr(vecs[i].addr, vecs[i].data);
            else mmio_rd($sformatf("vec%0d", i), vecs[i].addr, 9'(i), vecs[i].data);
        end

        // Back-to-back pops, no bubble.
        for (int k = 0; k < 3; k++) mmio_wr(16'h0020, 64'(8'hA1 + k));
        for (int k = 0; k < 3; k++) mmio_rd($sformatf("b2b%0d", k), 16'h0020, 9'(k + 1), 64'(8'hA1 + k));
        mmio_rd("b2b st", 16'h0022, 9'd9, ST_MT);

        // Flush, then flush combined with an overflow clear.
        for (int k = 1; k <= 5; k++) mmio_wr(16'h0020, 64'(k));
        mmio_rd("pre flush st", 16'h0022, 9'd1, 64'h5);
        mmio_wr(16'h0022, FLUSH_W);
        mmio_rd("flush st", 16'h0022, 9'd2, ST_MT);
        mmio_wr(16'h0020, 64'd42);
        mmio_rd("post flush", 16'h0020, 9'd3, 64'd42);
        for (int k = 0; k < 9; k++) mmio_wr(16'h0020, 64'(k));
        mmio_wr(16'h0022, FLUSH_W | 64'h0004_0000);
        mmio_rd("flush+clr st", 16'h0022, 9'd4, ST_MT);
        for (int k = 0; k < 20; k++) begin
            mmio_wr(16'h0020, 64'(100 + k));
            mmio_rd($sformatf("wrap%0d", k), 16'h0020, 9'(k), 64'(100 + k));
        end
        mmio_rd("wrap st", 16'h0022, 9'd5, ST_MT);

        // Reset spanning the edge that samples a read: no response.
        mmio_wr(16'h0020, 64'h55);
        mmio_rd("pre rst unf", 16'h0024, 9'd6, 64'h0);
        drive(1'b1, 1'b0, 16'h0020, 9'd3, 64'h0);
        #3 rst = 1'b1;
        #3 check("rst async tx", 64'(ccip.tx != '0), 64'd0);
        #1;
        drive(1'b0, 1'b0, 16'h0, 9'd0, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rst no rsp", 64'(ccip.tx.c2.mmioRdValid), 64'd0);

        // Reset while a response pulse is on the bus.
        drive(1'b1, 1'b0, 16'h0022, 9'd4, 64'h0);
        @(posedge clk);
        #2;
        drive(1'b0, 1'b0, 16'h0, 9'd0, 64'h0);
        rst = 1'b1;
        #1 check("rst kills pulse", 64'(ccip.tx.c2.mmioRdValid), 64'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst pulse gone", 64'(ccip.tx.c2.mmioRdValid), 64'd0);
        mmio_rd("rst st0", 16'h0022, 9'd7, ST_MT);
        mmio_rd("rst st1", 16'h0026, 9'd8, ST_MT);
        mmio_rd("rst data0", 16'h0020, 9'd9, 64'h0);

        // Narrow instance truncates on push and zero-extends on pop.
        mmio_wr(16'h0020, 64'hFFFF_FFFF_FFFF_ABCD);
        drive(1'b1, 1'b0, 16'h0020, 9'd7, 64'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 9'd0, 64'h0);
        check("w64 data", ccip.tx.c2.data, 64'hFFFF_FFFF_FFFF_ABCD);
        check("w16 vld", 64'(ccip16.tx.c2.mmioRdValid), 64'd1);
        check("w16 tid", 64'(ccip16.tx.c2.hdr.tid), 64'd7);
        check("w16 data", ccip16.tx.c2.data, 64'h0000_0000_0000_ABCD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
